// File: rtl/pwr_gate_seq.sv
// pwr_gate_seq: power-gating sequencer for one switchable domain.
//
// Brings a gated domain up (switch on, hold reset, release isolation) and
// back down (isolate, switch off) on the level of pwr_req. Watches the
// header switch power-good (sw_ack) with a bounded wait and traps to FAULT
// on timeout or brownout. FAULT is left only through fault_clr.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset, overrides all other inputs
//   pwr_req    1 = domain requested on, 0 = requested off (level)
//   sw_ack     switch power-good
//   fault_clr  leaves FAULT towards OFF
//   sw_en      header switch enable
//   iso_en     output isolation clamp enable
//   dom_rst    domain reset, active high
//   pwr_ack    domain powered, out of reset and un-isolated
//   fault      sequencing fault flag
//   ret_save, ret_restore   retention strobes (only with PWR_GATE_SEQ_RET_EN)
//
// Build option: define PWR_GATE_SEQ_RET_EN to add the retention SAVE and
// RESTORE states and their strobe outputs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OFF       | domain unpowered, isolated, in reset; waits for pwr_req
// SW_UP     | switch enabled, waiting for sw_ack (bounded by SW_TMO)
// RESTORE   | one-cycle retention restore strobe (retention build only)
// RST_HOLD  | powered, reset held for DLY cycles
// ISO_REL   | reset released, isolation still on for DLY cycles
// ON        | domain fully up; watches pwr_req drop and brownout
// ISO_SET   | isolation applied before switching off, DLY cycles
// SAVE      | one-cycle retention save strobe (retention build only)
// SW_DN     | switch disabled, waiting for sw_ack to drop (bounded)
// FAULT     | timeout or brownout; waits for fault_clr

module pwr_gate_seq #(
   parameter int unsigned SW_TMO = 255,
   parameter int unsigned DLY    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pwr_req,
   input  logic sw_ack,
   input  logic fault_clr,
   output logic sw_en,
   output logic iso_en,
   output logic dom_rst,
   output logic pwr_ack,
`ifdef PWR_GATE_SEQ_RET_EN
   output logic ret_save,
   output logic ret_restore,
`endif
   output logic fault
);

   localparam int unsigned CNT_MAX = (SW_TMO > DLY) ? SW_TMO : DLY;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   // Compare values are "last cycle in state": the counter reads 0 during
   // the first cycle after entry.
   localparam logic [CW-1:0] TMO_LAST = CW'(SW_TMO - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(DLY - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

   typedef enum logic [3:0] {
      S_OFF      = 4'd0,
      S_SW_UP    = 4'd1,
      S_RST_HOLD = 4'd2,
      S_ISO_REL  = 4'd3,
      S_ON       = 4'd4,
      S_ISO_SET  = 4'd5,
      S_SW_DN    = 4'd6,
      S_FAULT    = 4'd7
`ifdef PWR_GATE_SEQ_RET_EN
      ,
      S_SAVE     = 4'd8,
      S_RESTORE  = 4'd9
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic sw_en_q,   sw_en_d;
   logic iso_en_q,  iso_en_d;
   logic dom_rst_q, dom_rst_d;
   logic pwr_ack_q, pwr_ack_d;
   logic fault_q,   fault_d;
`ifdef PWR_GATE_SEQ_RET_EN
   logic ret_save_q,    ret_save_d;
   logic ret_restore_q, ret_restore_d;
`endif

   // Next state. A sampled ack always beats the timeout on the same cycle,
   // and brownout beats a power-down request in ON.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OFF: begin
            if (pwr_req) state_d = S_SW_UP;
         end
         S_SW_UP: begin
            if (sw_ack) begin
`ifdef PWR_GATE_SEQ_RET_EN
               state_d = S_RESTORE;
`else
               state_d = S_RST_HOLD;
`endif
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_FAULT;
            end
         end
`ifdef PWR_GATE_SEQ_RET_EN
         S_RESTORE: state_d = S_RST_HOLD;
         S_SAVE:    state_d = S_SW_DN;
`endif
         S_RST_HOLD: begin
            if (cnt_q == DLY_LAST) state_d = S_ISO_REL;
         end
         S_ISO_REL: begin
            if (cnt_q == DLY_LAST) state_d = S_ON;
         end
         S_ON: begin
            if (!sw_ack)       state_d = S_FAULT;
            else if (!pwr_req) state_d = S_ISO_SET;
         end
         S_ISO_SET: begin
            if (cnt_q == DLY_LAST) begin
`ifdef PWR_GATE_SEQ_RET_EN
               state_d = S_SAVE;
`else
               state_d = S_SW_DN;
`endif
            end
         end
         S_SW_DN: begin
            if (!sw_ack)                 state_d = S_OFF;
            else if (cnt_q == TMO_LAST)  state_d = S_FAULT;
         end
         S_FAULT: begin
            if (fault_clr) state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase
   end

   // Shared phase counter: restarts on every state change, saturates in
   // long-lived states so it never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)   cnt_d = '0;
      else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
   end

   // Output decode from the current state; the result is registered, so
   // pins follow the state one cycle later.
   always_comb begin
      sw_en_d   = 1'b0;
      iso_en_d  = 1'b1;
      dom_rst_d = 1'b1;
      pwr_ack_d = 1'b0;
      fault_d   = 1'b0;
`ifdef PWR_GATE_SEQ_RET_EN
      ret_save_d    = 1'b0;
      ret_restore_d = 1'b0;
`endif
      unique case (state_q)
         S_SW_UP, S_RST_HOLD: begin
            sw_en_d = 1'b1;
         end
`ifdef PWR_GATE_SEQ_RET_EN
         S_RESTORE: begin
            sw_en_d       = 1'b1;
            ret_restore_d = 1'b1;
         end
         S_SAVE: begin
            sw_en_d    = 1'b1;
            dom_rst_d  = 1'b0;
            ret_save_d = 1'b1;
         end
`endif
         S_ISO_REL, S_ISO_SET: begin
            sw_en_d   = 1'b1;
            dom_rst_d = 1'b0;
         end
         S_ON: begin
            sw_en_d   = 1'b1;
            iso_en_d  = 1'b0;
            dom_rst_d = 1'b0;
            pwr_ack_d = 1'b1;
         end
         S_FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            sw_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_OFF;
         cnt_q     <= '0;
         sw_en_q   <= 1'b0;
         iso_en_q  <= 1'b1;
         dom_rst_q <= 1'b1;
         pwr_ack_q <= 1'b0;
         fault_q   <= 1'b0;
`ifdef PWR_GATE_SEQ_RET_EN
         ret_save_q    <= 1'b0;
         ret_restore_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sw_en_q   <= sw_en_d;
         iso_en_q  <= iso_en_d;
         dom_rst_q <= dom_rst_d;
         pwr_ack_q <= pwr_ack_d;
         fault_q   <= fault_d;
`ifdef PWR_GATE_SEQ_RET_EN
         ret_save_q    <= ret_save_d;
         ret_restore_q <= ret_restore_d;
`endif
      end
   end

   assign sw_en   = sw_en_q;
   assign iso_en  = iso_en_q;
   assign dom_rst = dom_rst_q;
   assign pwr_ack = pwr_ack_q;
   assign fault   = fault_q;
`ifdef PWR_GATE_SEQ_RET_EN
   assign ret_save    = ret_save_q;
   assign ret_restore = ret_restore_q;
`endif

endmodule
